// File: rtl/regfile_bypass_p_if.sv
// Bundle for regfile_bypass_p: read ports, architectural write, forwarding network,
// pending scoreboard and hazard output. HI/LO signals exist only with REGFILE_HILO_EN.
interface regfile_bypass_p_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NSTG = 3
);
  logic [NRD*AW-1:0]  raddr;
  logic [NRD*DW-1:0]  rdata;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic [NSTG-1:0]    fwd_we;
  logic [NSTG-1:0]    fwd_ld;
  logic [NSTG*AW-1:0] fwd_waddr;
  logic [NSTG*DW-1:0] fwd_wdata;
  logic               pend_set;
  logic [AW-1:0]      pend_addr;
  logic               stall;
`ifdef REGFILE_HILO_EN
  logic               hi_we;
  logic               lo_we;
  logic [DW-1:0]      hi_i;
  logic [DW-1:0]      lo_i;
  logic [NSTG-1:0]    fwd_hi_we;
  logic [NSTG-1:0]    fwd_lo_we;
  logic [NSTG*DW-1:0] fwd_hi;
  logic [NSTG*DW-1:0] fwd_lo;
  logic [DW-1:0]      hi_out;
  logic [DW-1:0]      lo_out;
`endif

`ifdef REGFILE_HILO_EN
  modport master (
    output raddr, we, waddr, wdata, fwd_we, fwd_ld, fwd_waddr, fwd_wdata,
           pend_set, pend_addr, hi_we, lo_we, hi_i, lo_i,
           fwd_hi_we, fwd_lo_we, fwd_hi, fwd_lo,
    input  rdata, stall, hi_out, lo_out
  );
  modport slave (
    input  raddr, we, waddr, wdata, fwd_we, fwd_ld, fwd_waddr, fwd_wdata,
           pend_set, pend_addr, hi_we, lo_we, hi_i, lo_i,
           fwd_hi_we, fwd_lo_we, fwd_hi, fwd_lo,
    output rdata, stall, hi_out, lo_out
  );
`else
  modport master (
    output raddr, we, waddr, wdata, fwd_we, fwd_ld, fwd_waddr, fwd_wdata,
           pend_set, pend_addr,
    input  rdata, stall
  );
  modport slave (
    input  raddr, we, waddr, wdata, fwd_we, fwd_ld, fwd_waddr, fwd_wdata,
           pend_set, pend_addr,
    output rdata, stall
  );
`endif
endinterface

// File: rtl/regfile_bypass_p.sv
// Multi-port register file with pipeline forwarding, long-latency pending scoreboard
// and load-use stall detection. Optional HI/LO pair enabled by REGFILE_HILO_EN.
module regfile_bypass_p #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NSTG = 3
) (
  input logic              clk,
  input logic              resetn,
  regfile_bypass_p_if.slave bus
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [NRD-1:0]   port_stall;

  // Iterates oldest to youngest so the youngest valid stage overrides.
  function automatic logic [DW-1:0] pick_fwd(
    input logic [NSTG-1:0]    v,
    input logic [NSTG*DW-1:0] d,
    input logic [DW-1:0]      dflt
  );
    logic [DW-1:0] r;
    r = dflt;
    for (int unsigned i = 0; i < NSTG; i++) begin
      if (v[NSTG-1-i]) r = d[(NSTG-1-i)*DW +: DW];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem <= '{default: '0};
    end else if (bus.we && (bus.waddr != '0)) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Set is applied after clear so a same-cycle set on the same entry wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= '0;
    end else begin
      if (bus.we) pend[bus.waddr] <= 1'b0;
      if (bus.pend_set && (bus.pend_addr != '0)) pend[bus.pend_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [NSTG-1:0] mv;
    logic [NSTG-1:0] ymv;
    logic            whit;
    logic [DW-1:0]   d;

    assign a = bus.raddr[k*AW +: AW];

    for (genvar s = 0; s < NSTG; s++) begin : g_match
      assign mv[s] = bus.fwd_we[s] && (bus.fwd_waddr[s*AW +: AW] == a);
    end

    // Isolate the lowest set bit: the youngest matching stage.
    assign ymv  = mv & (~mv + 1'b1);
    assign whit = bus.we && (bus.waddr == a);
    assign d    = pick_fwd(mv, bus.fwd_wdata, whit ? bus.wdata : mem[a]);

    assign bus.rdata[k*DW +: DW] = (a == '0) ? '0 : d;
    assign port_stall[k] = (a != '0) &&
                           ((|(bus.fwd_ld & ymv)) || ((mv == '0) && !whit && pend[a]));
  end

  assign bus.stall = |port_stall;

`ifdef REGFILE_HILO_EN
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (bus.hi_we) hi_q <= bus.hi_i;
      if (bus.lo_we) lo_q <= bus.lo_i;
    end
  end

  assign bus.hi_out = pick_fwd(bus.fwd_hi_we, bus.fwd_hi, bus.hi_we ? bus.hi_i : hi_q);
  assign bus.lo_out = pick_fwd(bus.fwd_lo_we, bus.fwd_lo, bus.lo_we ? bus.lo_i : lo_q);
`endif
endmodule

// File: tb/tb_regfile_bypass_p.sv
// Directed scoreboard bench for regfile_bypass_p; HI/LO steps run only with REGFILE_HILO_EN.
module tb_regfile_bypass_p;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NSTG = 3;

  typedef struct {
    string         tag;
    int unsigned   sel;
    logic [DW-1:0] exp;
  } exp_t;

  logic clk;
  logic resetn;
  exp_t sb[$];
  int   checks;
  int   failures;

  regfile_bypass_p_if #(.DW(DW), .AW(AW), .NRD(NRD), .NSTG(NSTG)) bus ();

  regfile_bypass_p #(.DW(DW), .AW(AW), .NRD(NRD), .NSTG(NSTG)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // sel: 0 rdata port0, 1 rdata port1, 2 stall, 3 hi_out, 4 lo_out
  function automatic logic [DW-1:0] observe(input int unsigned sel);
    case (sel)
      0: return bus.rdata[DW-1:0];
      1: return bus.rdata[2*DW-1:DW];
      2: return {{(DW-1){1'b0}}, bus.stall};
`ifdef REGFILE_HILO_EN
      3: return bus.hi_out;
      4: return bus.lo_out;
`endif
      default: return 'x;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int unsigned sel, input logic [DW-1:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [DW-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    bus.raddr = '0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.fwd_we = '0; bus.fwd_ld = '0; bus.fwd_waddr = '0; bus.fwd_wdata = '0;
    bus.pend_set = 1'b0; bus.pend_addr = '0;
`ifdef REGFILE_HILO_EN
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.hi_i = '0; bus.lo_i = '0;
    bus.fwd_hi_we = '0; bus.fwd_lo_we = '0; bus.fwd_hi = '0; bus.fwd_lo = '0;
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.raddr = {a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
  endtask

  task automatic fwd(input int unsigned s, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic ld);
    bus.fwd_we[s] = 1'b1;
    bus.fwd_ld[s] = ld;
    bus.fwd_waddr[s*AW +: AW] = a;
    bus.fwd_wdata[s*DW +: DW] = d;
  endtask

  task automatic settle_check();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0;
    idle();

    // Reset state
    rd(5'd5, 5'd0);
    expect_val("rst_rd0", 0, 32'h0);
    expect_val("rst_rd1", 1, 32'h0);
    expect_val("rst_stall", 2, 32'h0);
    settle_check();
    #2 resetn = 1'b1;

    // First write after reset: same-cycle bypass, then stored value
    next_cycle();
    wr(5'd5, 32'hDEADBEEF); rd(5'd5, 5'd0);
    expect_val("wr_bypass", 0, 32'hDEADBEEF);
    expect_val("wr_r0port", 1, 32'h0);
    settle_check();

    next_cycle();
    rd(5'd5, 5'd5);
    expect_val("r5_stored_p0", 0, 32'hDEADBEEF);
    expect_val("r5_stored_p1", 1, 32'hDEADBEEF);
    settle_check();

    next_cycle();
    wr(5'd0, 32'h1); rd(5'd0, 5'd5);
    expect_val("r0_wr_byp", 0, 32'h0);
    settle_check();

    next_cycle();
    rd(5'd0, 5'd0);
    expect_val("r0_after_wr", 0, 32'h0);
    settle_check();

    // Forwarding priority
    next_cycle();
    wr(5'd3, 32'h99);
    settle_check();

    next_cycle();
    fwd(0, 5'd3, 32'h11, 1'b0); fwd(1, 5'd4, 32'h22, 1'b0); fwd(2, 5'd3, 32'h33, 1'b0);
    rd(5'd3, 5'd4);
    expect_val("fwd_youngest", 0, 32'h11);
    expect_val("fwd_stage1", 1, 32'h22);
    expect_val("fwd_nostall", 2, 32'h0);
    settle_check();

    next_cycle();
    fwd(2, 5'd3, 32'h33, 1'b0); wr(5'd3, 32'h77);
    rd(5'd3, 5'd3);
    expect_val("fwd_old_over_we", 0, 32'h33);
    settle_check();

    next_cycle();
    rd(5'd3, 5'd0);
    expect_val("r3_stored_77", 0, 32'h77);
    settle_check();

    // Load-use stall
    next_cycle();
    fwd(0, 5'd7, 32'h0, 1'b1); fwd(1, 5'd7, 32'h55, 1'b0); rd(5'd7, 5'd0);
    expect_val("ld_stall", 2, 32'h1);
    settle_check();

    next_cycle();
    fwd(0, 5'd7, 32'h0, 1'b0); fwd(1, 5'd7, 32'h55, 1'b0); rd(5'd7, 5'd0);
    expect_val("ld_ready_stall", 2, 32'h0);
    expect_val("ld_ready_data", 0, 32'h0);
    settle_check();

    next_cycle();
    fwd(0, 5'd7, 32'h0, 1'b0); fwd(1, 5'd7, 32'h55, 1'b1); rd(5'd0, 5'd7);
    expect_val("ld_older_masked", 2, 32'h0);
    expect_val("ld_older_data", 1, 32'h0);
    settle_check();

    // Pending scoreboard
    next_cycle();
    bus.pend_set = 1'b1; bus.pend_addr = 5'd9; rd(5'd9, 5'd0);
    expect_val("pend_setcyc", 2, 32'h0);
    settle_check();

    next_cycle();
    rd(5'd0, 5'd9);
    expect_val("pend_stall_p1", 2, 32'h1);
    settle_check();

    next_cycle();
    rd(5'd9, 5'd0);
    expect_val("pend_stall_hold", 2, 32'h1);
    settle_check();

    next_cycle();
    wr(5'd9, 32'h42); rd(5'd9, 5'd0);
    expect_val("pend_wr_nostall", 2, 32'h0);
    expect_val("pend_wr_data", 0, 32'h42);
    settle_check();

    next_cycle();
    rd(5'd9, 5'd0);
    expect_val("pend_clr_stall", 2, 32'h0);
    expect_val("pend_clr_data", 0, 32'h42);
    settle_check();

    next_cycle();
    wr(5'd9, 32'h43); bus.pend_set = 1'b1; bus.pend_addr = 5'd9;
    settle_check();

    next_cycle();
    rd(5'd9, 5'd0);
    expect_val("set_wins", 2, 32'h1);
    settle_check();

    // Pending plus forwarding match: forwarded value satisfies the read
    next_cycle();
    fwd(2, 5'd9, 32'h66, 1'b0); rd(5'd9, 5'd0);
    expect_val("pend_fwd_nostall", 2, 32'h0);
    expect_val("pend_fwd_data", 0, 32'h66);
    settle_check();

    // r4=0x7 and pending, then asynchronous reset mid-cycle
    next_cycle();
    wr(5'd4, 32'h7); bus.pend_set = 1'b1; bus.pend_addr = 5'd4;
    settle_check();

    next_cycle();
    rd(5'd4, 5'd0);
    expect_val("r4_pend_stall", 2, 32'h1);
    #2;
    check_all();
    resetn = 1'b0;
    #1;
    expect_val("async_rst_r4", 0, 32'h0);
    expect_val("async_rst_stall", 2, 32'h0);
    check_all();
    fwd(0, 5'd4, 32'h5, 1'b1);
    #1;
    expect_val("rst_fwd_ld_stall", 2, 32'h1);
    check_all();
    settle_check();
    #2 resetn = 1'b1;

    next_cycle();
    rd(5'd5, 5'd9);
    expect_val("post_rst_r5", 0, 32'h0);
    expect_val("post_rst_pend", 2, 32'h0);
    settle_check();

`ifdef REGFILE_HILO_EN
    next_cycle();
    bus.fwd_hi_we[1] = 1'b1; bus.fwd_hi[DW +: DW] = 32'hA;
    bus.hi_we = 1'b1; bus.hi_i = 32'hB;
    bus.lo_we = 1'b1; bus.lo_i = 32'hC;
    expect_val("hi_fwd", 3, 32'hA);
    expect_val("lo_byp", 4, 32'hC);
    settle_check();

    next_cycle();
    expect_val("hi_stored", 3, 32'hB);
    expect_val("lo_stored", 4, 32'hC);
    settle_check();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
